// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//   Loadable down-counter with optional auto-reload and a one-cycle
//   terminal-count pulse. Three-state FSM (IDLE / RUN / DONE); every output
//   comes straight from a register.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   reset        : asynchronous active-low reset
//   d            : start / reload value (WIDTH bits)
//   load         : capture d on the next edge (ignored when d == 0)
//   en           : count enable, only meaningful in RUN
//   auto_reload  : on expiry, reload the count instead of stopping
//   clear        : return to IDLE (lower priority than a valid load)
//   out          : current count (WIDTH bits)
//   tc           : terminal-count pulse, one cycle per expiry
//   busy         : high while in RUN
//   done         : high while in DONE
// -----------------------------------------------------------------------------
module countdown_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             load,
  input  logic             en,
  input  logic             auto_reload,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_reload;
  logic             r_tc;
  logic             r_busy;
  logic             r_done;

  // A zero load value is treated as if load were not asserted at all.
  logic w_load_ok;
  assign w_load_ok = load && (d != ZERO);

  // Timer FSM: count, reload register, state and registered status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_out    <= ZERO;
      r_reload <= ZERO;
      r_tc     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      // tc is a pulse: low unless this edge is an expiry.
      r_tc <= 1'b0;
      if (w_load_ok) begin
        r_out    <= d;
        r_reload <= d;
        r_state  <= ST_RUN;
        r_busy   <= 1'b1;
        r_done   <= 1'b0;
      end else if (clear) begin
        r_out   <= ZERO;
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          ST_RUN: begin
            if (en) begin
              if (r_out > ONE) begin
                r_out <= r_out - ONE;
              end else if (r_out == ONE) begin
                // Expiry edge: auto_reload is only looked at here.
                r_tc <= 1'b1;
                if (auto_reload) begin
                  r_out <= r_reload;
                end else begin
                  r_out   <= ZERO;
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end
              end else begin
                // Zero count in RUN cannot be reached; fall back to IDLE
                // rather than wrapping.
                r_out   <= ZERO;
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
              end
            end else begin
              r_out <= r_out;
            end
          end
          ST_IDLE: begin
            r_out  <= ZERO;
            r_busy <= 1'b0;
            r_done <= 1'b0;
          end
          ST_DONE: begin
            r_out  <= ZERO;
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
          default: begin
            r_out   <= ZERO;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out  = r_out;
  assign tc   = r_tc;
  assign busy = r_busy;
  assign done = r_done;

endmodule
